// File: rtl/clk_div_mc.sv
// Multi-channel glitch-free integer clock divider with boundary-aligned reconfiguration.
// Optional macro CLK_DIV_MC_ODD_DUTY50_EN adds a negedge stage for 50% duty on odd ratios.
module clk_div_mc #(
  parameter int NUM_CH  = 2,
  parameter int RATIO_W = 8
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst,
  input  logic [NUM_CH-1:0]         i_clk_en,
  input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]         o_div_clk,
  output logic [NUM_CH-1:0]         o_period_tick,
  output logic [NUM_CH-1:0]         o_ratio_ld
);

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2
  } state_e;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e             state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] r_q, r_d;
    logic [RATIO_W-1:0] ratio, h_len, l_len;
    logic               q_q, q_d;
    logic               byp_q, byp_d;
    logic               tick_q, tick_d;
    logic               ld_q, ld_d;
    logic               start;

    assign ratio = i_div_ratio[k*RATIO_W +: RATIO_W];
    assign start = i_clk_en[k] && (ratio > RATIO_W'(1));

`ifdef CLK_DIV_MC_ODD_DUTY50_EN
    assign h_len = r_q >> 1;
`else
    assign h_len = r_q - (r_q >> 1);
`endif
    assign l_len = r_q - h_len;

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= BYPASS;
        cnt_q   <= '0;
        r_q     <= '0;
        q_q     <= 1'b0;
        byp_q   <= 1'b1;
        tick_q  <= 1'b0;
        ld_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        r_q     <= r_d;
        q_q     <= q_d;
        byp_q   <= byp_d;
        tick_q  <= tick_d;
        ld_q    <= ld_d;
      end
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        BYPASS: if (start) state_d = HIGH;
        HIGH:   if (cnt_q == h_len) state_d = LOW;
        LOW:    if (cnt_q == l_len) state_d = start ? HIGH : BYPASS;
        default: state_d = BYPASS;
      endcase
    end

    always_comb begin
      cnt_d  = cnt_q;
      r_d    = r_q;
      q_d    = q_q;
      byp_d  = byp_q;
      tick_d = 1'b0;
      ld_d   = 1'b0;
      unique case (state_q)
        BYPASS: begin
          if (start) begin
            r_d    = ratio;
            q_d    = 1'b1;
            cnt_d  = RATIO_W'(1);
            byp_d  = 1'b0;
            tick_d = 1'b1;
            ld_d   = 1'b1;
          end else begin
            cnt_d = '0;
            q_d   = 1'b0;
            byp_d = 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == h_len) begin
            q_d   = 1'b0;
            cnt_d = RATIO_W'(1);
          end else begin
            cnt_d = cnt_q + RATIO_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == l_len) begin
            // q is low here, so handing over to the ref clock cannot make a runt
            if (start) begin
              r_d    = ratio;
              q_d    = 1'b1;
              cnt_d  = RATIO_W'(1);
              tick_d = 1'b1;
              ld_d   = (ratio != r_q);
            end else begin
              byp_d = 1'b1;
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + RATIO_W'(1);
          end
        end
        default: begin
          byp_d = 1'b1;
          cnt_d = '0;
          q_d   = 1'b0;
        end
      endcase
    end

`ifdef CLK_DIV_MC_ODD_DUTY50_EN
    logic qn_q;

    // Half-cycle stretch of the high phase, only for odd ratios
    always_ff @(negedge i_ref_clk or posedge i_rst) begin
      if (i_rst) qn_q <= 1'b0;
      else       qn_q <= q_q & r_q[0];
    end

    assign o_div_clk[k] = byp_q ? i_ref_clk : (q_q | qn_q);
`else
    assign o_div_clk[k] = byp_q ? i_ref_clk : q_q;
`endif

    assign o_period_tick[k] = tick_q;
    assign o_ratio_ld[k]    = ld_q;
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Scoreboard bench for clk_div_mc: per-half-cycle output level, tick and load pulses.
// Honours CLK_DIV_MC_ODD_DUTY50_EN when computing expected high times.
module tb_clk_div_mc;

  localparam int NUM_CH  = 2;
  localparam int RATIO_W = 8;

  logic        i_ref_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_clk_en = '0;
  logic [15:0] i_div_ratio = '0;
  logic [1:0]  o_div_clk;
  logic [1:0]  o_period_tick;
  logic [1:0]  o_ratio_ld;

  int      n_chk = 0;
  int      n_fail = 0;
  int      viol = 0;
  bit      mon_en = 1'b0;
  realtime last_t = 0;

  // each entry: {level in high half, level in low half, tick, ratio_ld}
  logic [3:0] sb0[$];
  logic [3:0] sb1[$];

  clk_div_mc #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W)) dut (
    .i_ref_clk    (i_ref_clk),
    .i_rst        (i_rst),
    .i_clk_en     (i_clk_en),
    .i_div_ratio  (i_div_ratio),
    .o_div_clk    (o_div_clk),
    .o_period_tick(o_period_tick),
    .o_ratio_ld   (o_ratio_ld)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  always @(posedge o_div_clk[0] or negedge o_div_clk[0]) begin
    if (mon_en && (($realtime - last_t) < 5.0)) viol++;
    last_t = $realtime;
  end

  task automatic push_div(input int ch, input int r, input bit ld1,
                          input int n);
    int hh;
    logic [3:0] v;
`ifdef CLK_DIV_MC_ODD_DUTY50_EN
    hh = r;
`else
    hh = 2 * (r - r / 2);
`endif
    for (int c = 0; c < n; c++) begin
      int p;
      p = c % r;
      v = {(2 * p < hh), (2 * p + 1 < hh), (p == 0), (ld1 && c == 0)};
      if (ch == 0) sb0.push_back(v);
      else         sb1.push_back(v);
    end
  endtask

  task automatic push_byp(input int ch, input int n);
    for (int c = 0; c < n; c++) begin
      if (ch == 0) sb0.push_back(4'b1000);
      else         sb1.push_back(4'b1000);
    end
  endtask

  task automatic sample(output logic [7:0] a);
    logic [1:0] hi, lo, tk, ld;
    @(posedge i_ref_clk);
    #1;
    hi = o_div_clk;
    tk = o_period_tick;
    ld = o_ratio_ld;
    @(negedge i_ref_clk);
    #1;
    lo = o_div_clk;
    a = {hi[0], lo[0], tk[0], ld[0], hi[1], lo[1], tk[1], ld[1]};
  endtask

  task automatic test_reset();
    logic [7:0] a, e;
    #1;
    n_chk++;
    if ({o_div_clk, o_period_tick, o_ratio_ld} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_t0: got clk/tick/ld=%b want 000000",
               {o_div_clk, o_period_tick, o_ratio_ld});
    end
    push_byp(0, 3);
    push_byp(1, 3);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b want %b", i, a, e);
      end
    end
    i_rst = 1'b0;
  endtask

  task automatic test_ratio2();
    logic [7:0] a, e;
    i_clk_en = 2'b01;
    i_div_ratio = {8'd0, 8'd2};
    push_div(0, 2, 1'b1, 40);
    push_byp(1, 40);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ratio2 cyc %0d: got %b want %b", i, a, e);
      end
    end
  endtask

  task automatic test_ratio5();
    logic [7:0] a, e;
    i_div_ratio = {8'd0, 8'd5};
    push_div(0, 5, 1'b1, 15);
    push_byp(1, 15);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ratio5 cyc %0d: got %b want %b", i, a, e);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [7:0] a, e;
    i_div_ratio = {8'd0, 8'd4};
    push_div(0, 4, 1'b1, 4);
    push_div(0, 6, 1'b1, 12);
    push_byp(1, 16);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ratio_chg cyc %0d: got %b want %b", i, a, e);
      end
      if (i == 1) i_div_ratio = {8'd0, 8'd6};
    end
  endtask

  task automatic test_disable();
    logic [7:0] a, e;
    int v0;
    i_div_ratio = {8'd0, 8'd8};
    push_div(0, 8, 1'b1, 8);
    push_byp(0, 6);
    push_byp(1, 14);
    v0 = viol;
    mon_en = 1'b1;
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL disable cyc %0d: got %b want %b", i, a, e);
      end
      if (i == 1) i_clk_en = 2'b00;
    end
    mon_en = 1'b0;
    n_chk++;
    if (viol - v0 !== 0) begin
      n_fail++;
      $display("FAIL disable_runt: got %0d narrow pulses want 0", viol - v0);
    end
  endtask

  task automatic test_low_ratio();
    logic [7:0] a, e;
    i_clk_en = 2'b11;
    i_div_ratio = {8'd1, 8'd0};
    push_byp(0, 10);
    push_byp(1, 10);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL low_ratio cyc %0d: got %b want %b", i, a, e);
      end
      if (i == 4) i_div_ratio = {8'd0, 8'd1};
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] a, e;
    i_clk_en = 2'b11;
    i_div_ratio = {8'd7, 8'd3};
    push_div(0, 3, 1'b1, 6);
    push_div(1, 7, 1'b1, 6);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL arst_pre cyc %0d: got %b want %b", i, a, e);
      end
    end
    i_rst = 1'b1;
    #1;
    n_chk++;
    if ({o_div_clk, o_period_tick, o_ratio_ld} !== 6'b000000) begin
      n_fail++;
      $display("FAIL arst_low: got clk/tick/ld=%b want 000000",
               {o_div_clk, o_period_tick, o_ratio_ld});
    end
    @(posedge i_ref_clk);
    #1;
    n_chk++;
    if ({o_div_clk, o_period_tick, o_ratio_ld} !== 6'b110000) begin
      n_fail++;
      $display("FAIL arst_high: got clk/tick/ld=%b want 110000",
               {o_div_clk, o_period_tick, o_ratio_ld});
    end
    @(negedge i_ref_clk);
    #1;
    i_rst = 1'b0;
    push_div(0, 3, 1'b1, 7);
    push_div(1, 7, 1'b1, 7);
    for (int i = 0; sb0.size() > 0; i++) begin
      sample(a);
      e = {sb0.pop_front(), sb1.pop_front()};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL arst_post cyc %0d: got %b want %b", i, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ratio2();
    test_ratio5();
    test_ratio_change();
    test_disable();
    test_low_ratio();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
